// File: rtl/fc_runner.sv
// Fully-connected classifier stage: int8 dot products, Q31 requantization, int8 logits.
// Optional FC_ARGMAX_EN adds running argmax outputs over the written logits.
module requant_q31 #(
    parameter int ACC_W   = 32,
    parameter int MUL_W   = 32,
    parameter int SHIFT_W = 6,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [ACC_W-1:0]   in_acc,
    input  logic signed [MUL_W-1:0]   mul_q31,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic signed [DATA_W-1:0]  zp_out,
    input  logic                      relu6_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_q
);
    localparam int PW = ACC_W + MUL_W + 32;
    localparam logic signed [PW-1:0] QMAX = PW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [PW-1:0] QMIN = -QMAX - PW'(1);

    logic                     full;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     rnd;
    logic signed [PW-1:0]     scaled;
    logic signed [PW-1:0]     sum;
    logic signed [PW-1:0]     lo;
    logic        [SHIFT_W:0]  sh;
    logic signed [DATA_W-1:0] sat;

    assign in_ready  = !full || out_ready;
    assign out_valid = full;

    // Round half up: add 2^(sh-1) before the arithmetic right shift by 31+shift.
    always_comb begin
        sh     = (SHIFT_W + 1)'(shift) + (SHIFT_W + 1)'(31);
        prod   = PW'(in_acc) * PW'(mul_q31);
        rnd    = PW'(1) <<< (sh - (SHIFT_W + 1)'(1));
        scaled = (prod + rnd) >>> sh;
        sum    = scaled + PW'(zp_out);
        lo     = relu6_en ? PW'(zp_out) : QMIN;
        if (sum > QMAX) begin
            sat = DATA_W'(QMAX);
        end else if (sum < lo) begin
            sat = DATA_W'(lo);
        end else begin
            sat = DATA_W'(sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            out_q <= '0;
        end else if (in_valid && in_ready) begin
            full  <= 1'b1;
            out_q <= sat;
        end else if (out_ready) begin
            full <= 1'b0;
        end
    end
endmodule

module fc_runner #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MUL_W   = 32,
    parameter int BIAS_W  = 32,
    parameter int SHIFT_W = 6,
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic        [DIM_W-1:0]   cfg_in_n,
    input  logic        [DIM_W-1:0]   cfg_out_n,
    input  logic        [ADDR_W-1:0]  cfg_in_base,
    input  logic        [ADDR_W-1:0]  cfg_w_base,
    input  logic        [ADDR_W-1:0]  cfg_out_base,
    input  logic signed [DATA_W-1:0]  cfg_in_zp,
    input  logic signed [DATA_W-1:0]  cfg_out_zp,
    input  logic signed [MUL_W-1:0]   cfg_mul,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    output logic                      in_rd_en,
    output logic        [ADDR_W-1:0]  in_rd_addr,
    input  logic signed [DATA_W-1:0]  in_rd_data,
    output logic                      w_rd_en,
    output logic        [ADDR_W-1:0]  w_rd_addr,
    input  logic signed [DATA_W-1:0]  w_rd_data,
    output logic        [DIM_W-1:0]   bias_idx,
    input  logic signed [BIAS_W-1:0]  bias,
`ifdef FC_ARGMAX_EN
    output logic        [DIM_W-1:0]   argmax_idx,
    output logic signed [DATA_W-1:0]  argmax_val,
`endif
    output logic                      out_wr_en,
    output logic        [ADDR_W-1:0]  out_wr_addr,
    output logic signed [DATA_W-1:0]  out_wr_data
);
    localparam int PRD_W = 2 * DATA_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_MAC, S_QUANT, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t state, nxt;

    logic        [DIM_W-1:0]   o, i, n_r, m_r;
    logic        [ADDR_W-1:0]  in_base_r, out_base_r, w_ptr;
    logic signed [DATA_W-1:0]  in_zp_r, out_zp_r;
    logic signed [MUL_W-1:0]   mul_r;
    logic        [SHIFT_W-1:0] shift_r;
    logic signed [ACC_W-1:0]   acc;
    logic signed [PRD_W-1:0]   dx, prd;

    logic                      rq_in_valid, rq_in_ready;
    logic                      rq_out_valid, rq_out_ready;
    logic signed [DATA_W-1:0]  rq_q;

    requant_q31 #(
        .ACC_W(ACC_W), .MUL_W(MUL_W), .SHIFT_W(SHIFT_W), .DATA_W(DATA_W)
    ) u_rq (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rq_in_valid),
        .in_ready (rq_in_ready),
        .in_acc   (acc),
        .mul_q31  (mul_r),
        .shift    (shift_r),
        .zp_out   (out_zp_r),
        .relu6_en (1'b0),
        .out_valid(rq_out_valid),
        .out_ready(rq_out_ready),
        .out_q    (rq_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = (cfg_out_n == '0) ? S_DONE : S_BIAS;
            S_BIAS:  nxt = (n_r == '0) ? S_QUANT : S_MAC;
            S_MAC:   if (i == n_r - DIM_W'(1)) nxt = S_QUANT;
            S_QUANT: if (rq_in_ready) nxt = S_WRITE;
            S_WRITE: if (rq_out_valid) nxt = S_NEXT;
            S_NEXT:  nxt = (o == m_r - DIM_W'(1)) ? S_DONE : S_BIAS;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        bias_idx     = o;
        in_rd_en     = (state == S_MAC);
        w_rd_en      = (state == S_MAC);
        in_rd_addr   = in_rd_en ? in_base_r + ADDR_W'(i) : '0;
        w_rd_addr    = w_rd_en ? w_ptr : '0;
        rq_in_valid  = (state == S_QUANT);
        rq_out_ready = (state == S_WRITE);
        out_wr_en    = (state == S_WRITE) && rq_out_valid;
        out_wr_addr  = out_wr_en ? out_base_r + ADDR_W'(o) : '0;
        out_wr_data  = out_wr_en ? rq_q : '0;
    end

    // Zero-point difference is one bit wider than the data; product fits 2*DATA_W+1.
    always_comb begin
        dx  = PRD_W'(in_rd_data) - PRD_W'(in_zp_r);
        prd = dx * PRD_W'(w_rd_data);
    end

    // Weights are row-major and contiguous, so one pointer walks them across rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o          <= '0;
            i          <= '0;
            n_r        <= '0;
            m_r        <= '0;
            in_base_r  <= '0;
            out_base_r <= '0;
            w_ptr      <= '0;
            in_zp_r    <= '0;
            out_zp_r   <= '0;
            mul_r      <= '0;
            shift_r    <= '0;
            acc        <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    o          <= '0;
                    i          <= '0;
                    n_r        <= cfg_in_n;
                    m_r        <= cfg_out_n;
                    in_base_r  <= cfg_in_base;
                    out_base_r <= cfg_out_base;
                    w_ptr      <= cfg_w_base;
                    in_zp_r    <= cfg_in_zp;
                    out_zp_r   <= cfg_out_zp;
                    mul_r      <= cfg_mul;
                    shift_r    <= cfg_shift;
                end
                S_BIAS: begin
                    acc <= ACC_W'(bias);
                    i   <= '0;
                end
                S_MAC: begin
                    acc   <= acc + ACC_W'(prd);
                    i     <= i + DIM_W'(1);
                    w_ptr <= w_ptr + ADDR_W'(1);
                end
                S_NEXT: if (o != m_r - DIM_W'(1)) begin
                    o <= o + DIM_W'(1);
                    i <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef FC_ARGMAX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            argmax_idx <= '0;
            argmax_val <= '0;
        end else if (state == S_IDLE && start) begin
            argmax_idx <= '0;
            argmax_val <= '0;
        end else if (out_wr_en && (o == '0 || rq_q > argmax_val)) begin
            argmax_idx <= o;
            argmax_val <= rq_q;
        end
    end
`endif
endmodule

// File: tb/tb_fc_runner.sv
// Self-checking bench for fc_runner: directed and random layers vs an arithmetic model.
// Define FC_ARGMAX_EN to also exercise the argmax outputs.
module tb_fc_runner;
    localparam int IB = 16;
    localparam int WB = 200;
    localparam int OB = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, busy, done;
    logic        [15:0] cfg_in_n, cfg_out_n;
    logic        [31:0] cfg_in_base, cfg_w_base, cfg_out_base;
    logic signed [7:0]  cfg_in_zp, cfg_out_zp;
    logic signed [31:0] cfg_mul;
    logic        [5:0]  cfg_shift;
    logic               in_rd_en, w_rd_en, out_wr_en;
    logic        [31:0] in_rd_addr, w_rd_addr, out_wr_addr;
    logic signed [7:0]  in_rd_data, w_rd_data, out_wr_data;
    logic        [15:0] bias_idx;
    logic signed [31:0] bias;
`ifdef FC_ARGMAX_EN
    logic        [15:0] argmax_idx;
    logic signed [7:0]  argmax_val;
`endif

    logic signed [7:0]  in_mem   [0:2047];
    logic signed [7:0]  w_mem    [0:2047];
    logic signed [31:0] bias_mem [0:63];

    assign in_rd_data = in_mem[in_rd_addr[10:0]];
    assign w_rd_data  = w_mem[w_rd_addr[10:0]];
    assign bias       = bias_mem[bias_idx[5:0]];

    fc_runner dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cfg_in_n(cfg_in_n), .cfg_out_n(cfg_out_n),
        .cfg_in_base(cfg_in_base), .cfg_w_base(cfg_w_base),
        .cfg_out_base(cfg_out_base), .cfg_in_zp(cfg_in_zp),
        .cfg_out_zp(cfg_out_zp), .cfg_mul(cfg_mul), .cfg_shift(cfg_shift),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .bias_idx(bias_idx), .bias(bias),
`ifdef FC_ARGMAX_EN
        .argmax_idx(argmax_idx), .argmax_val(argmax_val),
`endif
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .out_wr_data(out_wr_data)
    );

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int wa_q[$];
    int wd_q[$];

    always @(posedge clk) begin
        if (out_wr_en) begin
            wa_q.push_back(int'(out_wr_addr));
            wd_q.push_back(int'(out_wr_data));
        end
        if (in_rd_en || w_rd_en) rd_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int n, m, izp, ozp, mul, sh;

    function automatic int requant(input int acc);
        longint p, d, q, r;
        p = longint'(acc) * longint'(mul);
        d = longint'(1) <<< (31 + sh);
        q = p + d / 2;
        if (q >= 0) r = q / d;
        else        r = -((-q + d - 1) / d);
        r = r + ozp;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    function automatic int expect_out(input int o);
        int acc;
        acc = bias_mem[o];
        for (int k = 0; k < n; k++)
            acc += (int'(in_mem[IB + k]) - izp) * int'(w_mem[WB + o * n + k]);
        return requant(acc);
    endfunction

    task automatic drive_cfg();
        cfg_in_n     = 16'(n);
        cfg_out_n    = 16'(m);
        cfg_in_base  = IB;
        cfg_w_base   = WB;
        cfg_out_base = OB;
        cfg_in_zp    = 8'(izp);
        cfg_out_zp   = 8'(ozp);
        cfg_mul      = mul;
        cfg_shift    = 6'(sh);
    endtask

    task automatic run(input string tag, input bit restart, output int lat);
        int cyc;
        wa_q.delete();
        wd_q.delete();
        rd_cnt   = 0;
        done_cnt = 0;
        @(negedge clk);
        drive_cfg();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 5000) begin
            if (restart && cyc == 3) begin
                cfg_out_n = 16'(m + 3);
                cfg_in_n  = 16'(n + 1);
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        lat = cyc;
        check({tag, "_timeout"}, longint'(cyc < 5000), 1);
        @(negedge clk);
        check({tag, "_busy_after"}, longint'(busy), 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_wr_count"}, wa_q.size(), m);
        for (int o = 0; o < m && o < wa_q.size(); o++) begin
            check($sformatf("%s_addr%0d", tag, o), wa_q[o], OB + o);
            check($sformatf("%s_data%0d", tag, o), wd_q[o], expect_out(o));
        end
    endtask

    initial begin
        int lat, wr_before, done_before, cyc;
        rst_n = 1'b0;
        start = 1'b0;
        n = 0; m = 0; izp = 0; ozp = 0; mul = 0; sh = 0;
        drive_cfg();
        for (int k = 0; k < 2048; k++) begin
            in_mem[k] = '0;
            w_mem[k]  = '0;
        end
        for (int k = 0; k < 64; k++) bias_mem[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", out_wr_en, 0);
        check("rst_rd_en", longint'(in_rd_en | w_rd_en), 0);
        check("rst_bias_idx", bias_idx, 0);
        check("rst_addrs", longint'(in_rd_addr | w_rd_addr | out_wr_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic dot product
        n = 4; m = 2; izp = 0; ozp = 0; mul = 32'h40000000; sh = 0;
        for (int k = 0; k < 4; k++) in_mem[IB + k] = 8'(k + 1);
        for (int k = 0; k < 4; k++) w_mem[WB + k] = 8'sd1;
        w_mem[WB + 4] = -8'sd1; w_mem[WB + 5] = 0;
        w_mem[WB + 6] = 0;      w_mem[WB + 7] = 8'sd2;
        bias_mem[0] = 10; bias_mem[1] = -5;
        run("basic", 1'b0, lat);
        check("basic_out0", wd_q.size() > 0 ? wd_q[0] : -999, 10);
        check("basic_out1", wd_q.size() > 1 ? wd_q[1] : -999, 1);
        check("basic_reads", rd_cnt, 8);

        // Zero points
        n = 4; m = 1; izp = 1; ozp = 3;
        for (int k = 0; k < 4; k++) begin
            in_mem[IB + k] = 8'sd1;
            w_mem[WB + k]  = 8'sd5;
        end
        bias_mem[0] = 0;
        run("zp", 1'b0, lat);
        check("zp_out", wd_q.size() > 0 ? wd_q[0] : -999, 3);

        // Saturation both ways
        n = 1; m = 1; izp = 0; ozp = 0; mul = 32'h7FFFFFFF; sh = 0;
        in_mem[IB] = 0;
        bias_mem[0] = 1000;
        run("sat_hi", 1'b0, lat);
        check("sat_hi_out", wd_q.size() > 0 ? wd_q[0] : -999, 127);
        bias_mem[0] = -1000;
        run("sat_lo", 1'b0, lat);
        check("sat_lo_out", wd_q.size() > 0 ? wd_q[0] : -999, -128);

        // M = 0
        n = 4; m = 0;
        run("m0", 1'b0, lat);
        check("m0_reads", rd_cnt, 0);
        check("m0_latency_le2", longint'(lat <= 2), 1);

        // N = 0
        n = 0; m = 1; mul = 32'h40000000; sh = 0;
        bias_mem[0] = 8;
        run("n0", 1'b0, lat);
        check("n0_out", wd_q.size() > 0 ? wd_q[0] : -999, 4);

        // Random layers
        for (int t = 0; t < 6; t++) begin
            n   = $urandom_range(0, 8);
            m   = $urandom_range(1, 6);
            izp = $urandom_range(0, 40) - 20;
            ozp = $urandom_range(0, 40) - 20;
            mul = $urandom_range(32'h7FFFFFFF, 32'h08000000);
            sh  = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) in_mem[IB + k] = 8'($urandom);
            for (int k = 0; k < n * m; k++) w_mem[WB + k] = 8'($urandom);
            for (int k = 0; k < m; k++)
                bias_mem[k] = $urandom_range(0, 4000) - 2000;
            run($sformatf("rnd%0d", t), 1'b0, lat);
        end

        // Start while busy is ignored
        n = 3; m = 3; izp = 2; ozp = -1; mul = 32'h30000000; sh = 1;
        for (int k = 0; k < n; k++) in_mem[IB + k] = 8'($urandom);
        for (int k = 0; k < n * m; k++) w_mem[WB + k] = 8'($urandom);
        for (int k = 0; k < m; k++) bias_mem[k] = $urandom_range(0, 600) - 300;
        run("restart", 1'b1, lat);

        // Reset during MAC of output 1
        n = 4; m = 3; izp = 0; ozp = 0; mul = 32'h40000000; sh = 0;
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        @(negedge clk);
        drive_cfg();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(in_rd_en && bias_idx == 16'd1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mrst_reach_mac1", longint'(cyc < 200), 1);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_rd_en", longint'(in_rd_en | w_rd_en), 0);
        check("mrst_bias_idx", bias_idx, 0);
        check("mrst_wr_en", out_wr_en, 0);
        wr_before   = wa_q.size();
        done_before = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("mrst_writes", wa_q.size(), wr_before);
        check("mrst_writes_one", wr_before, 1);
        check("mrst_no_done", done_cnt, done_before);
        check("mrst_idle", busy, 0);

`ifdef FC_ARGMAX_EN
        n = 0; m = 3; mul = 32'h40000000; sh = 0; ozp = 0;
        bias_mem[0] = 20; bias_mem[1] = 2; bias_mem[2] = 20;
        run("amax", 1'b0, lat);
        check("amax_idx", argmax_idx, 0);
        check("amax_val", argmax_val, 10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_runner.md
Name: fc_runner

Overview:
- Fully-connected classifier stage directly downstream of the global-average-pool stage.
- Consumes the per-channel int8 GAP vector from activation memory and reads int8 weights row-major plus int32 per-output bias.
- Accumulates in ACC_W, requantizes each output through a requant_q31 instance, and writes int8 logits to output memory.
- Sequenced by a start/done FSM, one output neuron at a time.

Parameters:
- DATA_W, 8, activation/weight/output width (signed)
- ACC_W, 32, accumulator width
- MUL_W, 32, Q31 requant multiplier width
- BIAS_W, 32, bias width
- SHIFT_W, 6, requant shift width
- ADDR_W, 32, memory address width
- DIM_W, 16, dimension/index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin layer; sampled only in S_IDLE
- busy  out  1  high whenever state != S_IDLE
- done  out  1  one-cycle pulse at completion
- cfg_in_n  in  DIM_W  input vector length N
- cfg_out_n  in  DIM_W  number of outputs M
- cfg_in_base  in  ADDR_W  activation base address
- cfg_w_base  in  ADDR_W  weight base address
- cfg_out_base  in  ADDR_W  output base address
- cfg_in_zp  in  DATA_W  signed input zero point
- cfg_out_zp  in  DATA_W  signed output zero point
- cfg_mul  in  MUL_W  signed Q31 multiplier
- cfg_shift  in  SHIFT_W  requant right shift
- in_rd_en  out  1  activation read strobe
- in_rd_addr  out  ADDR_W  activation address
- in_rd_data  in  DATA_W  signed; valid same cycle as address (combinational read)
- w_rd_en  out  1  weight read strobe
- w_rd_addr  out  ADDR_W  weight address
- w_rd_data  in  DATA_W  signed; same-cycle read
- bias_idx  out  DIM_W  current output index
- bias  in  BIAS_W  signed bias for bias_idx; same-cycle
- out_wr_en  out  1  output write strobe
- out_wr_addr  out  ADDR_W  output address
- out_wr_data  out  DATA_W  signed requantized result

Behaviour:
- Reset: state=S_IDLE; done=0, bias_idx=0, all strobes/addresses/data=0, internal counters and acc=0, config registers cleared.
- Reset asserted mid-operation returns to S_IDLE immediately, with no write and no done.
- Config registers are captured on start in S_IDLE. Config changes while busy have no effect.
- start while busy is ignored.
- States: S_IDLE, S_BIAS, S_MAC, S_QUANT, S_WRITE, S_NEXT, S_DONE.
- S_IDLE --start--> S_BIAS, clearing o (bias_idx) and i.
  - If captured M==0: go to S_DONE instead; no reads, no writes.
- S_BIAS (1 cycle): acc <= sign-extended bias.
  - Next state is S_MAC, or S_QUANT if N==0.
- S_MAC (N cycles, i=0..N-1):
  - in_rd_en=w_rd_en=1
  - in_rd_addr = in_base + i
  - w_rd_addr = w_base + o*N + i
  - acc <= acc + (in_rd_data - in_zp) * w_rd_data
  - Difference is DATA_W+1 signed; product is sign-extended to ACC_W.
  - acc wraps modulo 2^ACC_W; no saturation.
  - After i==N-1: go to S_QUANT.
- S_QUANT: requant in_valid=1 with in_acc=acc, mul_q31=cfg_mul, shift=cfg_shift, zp_out=cfg_out_zp, relu6_en=0.
  - Advance to S_WRITE on in_ready.
- S_WRITE: out_ready=1.
  - On out_valid: in the same cycle, out_wr_en=1, out_wr_addr=out_base+o, out_wr_data=out_q.
  - Then go to S_NEXT.
  - Saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1] is performed by requant_q31.
- S_NEXT: if o==M-1, go to S_DONE; else o++, i=0, go to S_BIAS.
- S_DONE: done=1 for exactly one cycle, then S_IDLE.
- Exactly M writes per run, at strictly increasing addresses.
- Per-output cycles = 1 + N + requant handshake + 1.

Optional Feature:
- Macro: FC_ARGMAX_EN.
- When defined, adds two ports:
  - argmax_idx  out  DIM_W
  - argmax_val  out  DATA_W  signed
- Tracking rule: on each output write, update if o==0 or out_q > current max (strict; ties keep the lowest index).
- argmax_idx/argmax_val hold their values from done until the next start. Both reset to 0 and are cleared at start.
- When undefined: ports are absent and no compare logic is built.

Test Plan:
- Basic dot product: N=4, M=2, in=[1,2,3,4], in_zp=0, W row0=[1,1,1,1], row1=[-1,0,0,2], bias=[10,-5], mul=0x40000000, shift=0, out_zp=0 -> writes out[base]=10, out[base+1]=1; done pulses once; busy low afterward.
- Zero points: in=[1,1,1,1], in_zp=1, W all 5, bias=0, out_zp=3 -> single output 3.
- Saturation: N=1, in=0, bias=1000, mul=0x7FFFFFFF, shift=0 -> output 127. Same with bias=-1000 -> -128.
- Degenerate sizes:
  - M=0 -> no reads, no writes, done within 2 cycles of start.
  - N=0, M=1, bias=8, mul=0x40000000 -> output 4.
- Robustness: reset asserted during S_MAC of output 1 -> outputs return to 0, no further writes, no done. A second start while busy is ignored; write count still equals M.
- FC_ARGMAX_EN: outputs [10,1,10] -> argmax_idx=0, argmax_val=10.
